mbinit_sb_tx_arbiter: RTL

//  Round-robin arbiter and sequencer for the shared sideband TX message path in MBINIT.

---
 rtl/mbinit_sb_tx_arbiter_if.sv | 35 +++
 rtl/mbinit_sb_tx_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mbinit_sb_tx_arbiter_if.sv
// Bundle of the sideband TX arbiter handshake signals.
//   req               requester levels, held until done/timeout
//   msg               requester messages, requester k at [k*SB_MSG_WIDTH +: SB_MSG_WIDTH]
//   falling_edge_busy serializer completion pulse
//   grant             one-hot current owner
//   tx_sb_message     latched message of the owner, 0 when there is no owner
//   valid_out_data    1-cycle issue strobe to the serializer
//   done              one-hot 1-cycle completion pulse
//   timeout           1-cycle abort pulse
//   busy              a message is being issued or awaited
// master: requesters + serializer side.  slave: the arbiter.
interface mbinit_sb_tx_arbiter_if #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned SB_MSG_WIDTH = 4
);
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*SB_MSG_WIDTH-1:0] msg;
    logic                            falling_edge_busy;
    logic [NUM_REQ-1:0]              grant;
    logic [SB_MSG_WIDTH-1:0]         tx_sb_message;
    logic                            valid_out_data;
    logic [NUM_REQ-1:0]              done;
    logic                            timeout;
    logic                            busy;

    modport master (
        output req, msg, falling_edge_busy,
        input  grant, tx_sb_message, valid_out_data, done, timeout, busy
    );

    modport slave (
        input  req, msg, falling_edge_busy,
        output grant, tx_sb_message, valid_out_data, done, timeout, busy
    );
endinterface

// File: rtl/mbinit_sb_tx_arbiter.sv
// Round-robin arbiter/sequencer for the shared MBINIT sideband TX path.
// One message is issued at a time; the grant is held until the serializer
// reports completion (busy falling edge) or TIMEOUT_CYCLES elapse.
// Ports:
//   CLK  clock, all state on the rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of mbinit_sb_tx_arbiter_if (requests, messages,
//        completion pulse in; grant, message, strobes, busy out)
module mbinit_sb_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned SB_MSG_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     CLK,
    input  logic                     rst,
    mbinit_sb_tx_arbiter_if.slave    bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        last;
    logic [IDX_W-1:0]        owner;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_REQ-1:0]      grant_q;
    logic [SB_MSG_WIDTH-1:0] msg_q;
    logic                    valid_q;
    logic [NUM_REQ-1:0]      done_q;
    logic                    timeout_q;
    logic                    busy_q;

    logic [NUM_REQ-1:0]      cand;
    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [SB_MSG_WIDTH-1:0] win_msg;
    int unsigned             scan_idx;

    // Winner search: rotate from last+1; the requester that completed in the
    // previous cycle sits out one arbitration so it has time to drop req.
    always_comb begin
        cand      = bus.req;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        if ((done_q != '0) || timeout_q) begin
            cand[last] = 1'b0;
        end
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = (32'(last) + i) % NUM_REQ;
            if (!win_found && cand[IDX_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_idx);
            end
        end
        win_msg = bus.msg[32'(win_idx) * SB_MSG_WIDTH +: SB_MSG_WIDTH];
    end

    // Sequencer: IDLE -> ISSUE (1 cycle) -> WAIT_DONE -> IDLE.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            owner     <= '0;
            cnt       <= '0;
            grant_q   <= '0;
            msg_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner   <= win_idx;
                        grant_q <= NUM_REQ'(1) << win_idx;
                        msg_q   <= win_msg;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A busy edge seen here belongs to an older message.
                    cnt   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.falling_edge_busy) begin
                        done_q  <= grant_q;
                        grant_q <= '0;
                        msg_q   <= '0;
                        busy_q  <= 1'b0;
                        last    <= owner;
                        state   <= IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                        msg_q     <= '0;
                        busy_q    <= 1'b0;
                        last      <= owner;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant          = grant_q;
    assign bus.tx_sb_message  = msg_q;
    assign bus.valid_out_data = valid_q;
    assign bus.done           = done_q;
    assign bus.timeout        = timeout_q;
    assign bus.busy           = busy_q;

endmodule
